// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel-clock divider, h/v counters, visible-area decode
// and a one-pixel output register stage that keeps colour and sync aligned.
module vga_timing #(
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned PIX_DIV   = 2
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       R_IN,
  input  logic       G_IN,
  input  logic       B_IN,
  output logic [9:0] X_VGA,
  output logic [9:0] Y_VGA,
  output logic       VIDEO_ON,
  output logic       PIX_TICK,
  output logic       FRAME_START,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;
  localparam int unsigned H_W     = ($clog2(H_TOTAL) < 10) ? 10 : $clog2(H_TOTAL);
  localparam int unsigned V_W     = ($clog2(V_TOTAL) < 10) ? 10 : $clog2(V_TOTAL);
  localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0]   H_SYNC_C = H_W'(H_SYNC);
  localparam logic [V_W-1:0]   V_SYNC_C = V_W'(V_SYNC);
  localparam logic [H_W-1:0]   H_START  = H_W'(H_SYNC + H_BACK);
  localparam logic [H_W-1:0]   H_END    = H_W'(H_SYNC + H_BACK + H_VISIBLE);
  localparam logic [V_W-1:0]   V_START  = V_W'(V_SYNC + V_BACK);
  localparam logic [V_W-1:0]   V_END    = V_W'(V_SYNC + V_BACK + V_VISIBLE);

  logic [DIV_W-1:0] div;
  logic [H_W-1:0]   h_count;
  logic [V_W-1:0]   v_count;
  logic             pix_tick;
  logic             h_last;
  logic             v_last;
  logic             video_on;
  logic             raw_hsync;
  logic             raw_vsync;

  assign pix_tick = (div == DIV_LAST);
  assign h_last   = (h_count == H_LAST);
  assign v_last   = (v_count == V_LAST);

  // Pixel-rate divider
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (pix_tick) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Raster counters; v advances on the same tick that h wraps
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
    end else if (pix_tick) begin
      if (h_last) begin
        h_count <= '0;
        v_count <= v_last ? '0 : v_count + V_W'(1);
      end else begin
        h_count <= h_count + H_W'(1);
      end
    end
  end

  always_comb begin
    video_on  = (h_count >= H_START) && (h_count < H_END) &&
                (v_count >= V_START) && (v_count < V_END);
    raw_hsync = !(h_count < H_SYNC_C);
    raw_vsync = !(v_count < V_SYNC_C);
  end

  // Coordinates are forced to 0 off-screen so no wrapped negative value leaks out
  assign X_VGA       = video_on ? 10'(h_count - H_START) : 10'd0;
  assign Y_VGA       = video_on ? 10'(v_count - V_START) : 10'd0;
  assign VIDEO_ON    = video_on;
  assign PIX_TICK    = pix_tick;
  assign FRAME_START = pix_tick && h_last && v_last;

  // Colour and sync share one register stage so they stay aligned on the wire
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      HSYNC <= 1'b1;
      VSYNC <= 1'b1;
      VGA_R <= 8'h00;
      VGA_G <= 8'h00;
      VGA_B <= 8'h00;
    end else if (pix_tick) begin
      HSYNC <= raw_hsync;
      VSYNC <= raw_vsync;
      VGA_R <= video_on ? {8{R_IN}} : 8'h00;
      VGA_G <= video_on ? {8{G_IN}} : 8'h00;
      VGA_B <= video_on ? {8{B_IN}} : 8'h00;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing on a shrunken raster: a counting model checks the decode each
// cycle and a scoreboard queue checks the registered colour/sync one pixel later.
module tb_vga_timing;

  localparam int unsigned HS = 4, HB = 3, HV = 8, HF = 2;
  localparam int unsigned VS = 2, VB = 2, VV = 4, VF = 1;
  localparam int unsigned PD = 2;
  localparam int unsigned HT = HS + HB + HV + HF;
  localparam int unsigned VT = VS + VB + VV + VF;
  localparam int unsigned FRAME_TICKS = HT * VT;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
  } reg_out_t;

  localparam reg_out_t RESET_OUT = '{r: 8'h00, g: 8'h00, b: 8'h00, hs: 1'b1, vs: 1'b1};

  logic       CLK = 1'b0;
  logic       reset;
  logic       r_in, g_in, b_in;
  logic [9:0] x0, y0, x1, y1;
  logic       von0, tick0, fs0, hs0, vs0;
  logic       von1, tick1, fs1, hs1, vs1;
  logic [7:0] vr0, vg0, vb0, vr1, vg1, vb1;

  vga_timing #(.H_SYNC(HS), .H_BACK(HB), .H_VISIBLE(HV), .H_FRONT(HF),
               .V_SYNC(VS), .V_BACK(VB), .V_VISIBLE(VV), .V_FRONT(VF), .PIX_DIV(PD)) u0 (
    .CLK(CLK), .reset(reset), .R_IN(r_in), .G_IN(g_in), .B_IN(b_in),
    .X_VGA(x0), .Y_VGA(y0), .VIDEO_ON(von0), .PIX_TICK(tick0), .FRAME_START(fs0),
    .HSYNC(hs0), .VSYNC(vs0), .VGA_R(vr0), .VGA_G(vg0), .VGA_B(vb0));

  vga_timing #(.H_SYNC(HS), .H_BACK(HB), .H_VISIBLE(HV), .H_FRONT(HF),
               .V_SYNC(VS), .V_BACK(VB), .V_VISIBLE(VV), .V_FRONT(VF), .PIX_DIV(1)) u1 (
    .CLK(CLK), .reset(reset), .R_IN(r_in), .G_IN(g_in), .B_IN(b_in),
    .X_VGA(x1), .Y_VGA(y1), .VIDEO_ON(von1), .PIX_TICK(tick1), .FRAME_START(fs1),
    .HSYNC(hs1), .VSYNC(vs1), .VGA_R(vr1), .VGA_G(vg1), .VGA_B(vb1));

  always #5 CLK = ~CLK;

  int       compared = 0;
  int       mismatched = 0;
  reg_out_t sb_q[$];
  reg_out_t held;
  logic     tick_pending;
  int       k;
  int       pops, hs_low, vs_low;
  int       last_fs0, last_fs1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  // Decode model from edge count since reset release
  task automatic check_comb(input string who, input int pd, input int kk, input logic tick,
                            input logic von, input logic [9:0] x, input logic [9:0] y,
                            input logic fs);
    int  n, d, h, v;
    bit  vis, et;
    n   = kk / pd;
    d   = kk % pd;
    h   = n % HT;
    v   = (n / HT) % VT;
    et  = (d == pd - 1);
    vis = (h >= HS + HB) && (h < HS + HB + HV) && (v >= VS + VB) && (v < VS + VB + VV);
    check({who, ".pix_tick"}, 32'(tick), 32'(et));
    check({who, ".video_on"}, 32'(von), 32'(vis));
    check({who, ".x_vga"}, 32'(x), vis ? 32'(h - (HS + HB)) : 32'd0);
    check({who, ".y_vga"}, 32'(y), vis ? 32'(v - (VS + VB)) : 32'd0);
    check({who, ".frame_start"}, 32'(fs), 32'(et && h == HT - 1 && v == VT - 1));
  endtask

  task automatic restart_model();
    k            = 0;
    sb_q.delete();
    held         = RESET_OUT;
    tick_pending = 1'b0;
    pops         = 0;
    hs_low       = 0;
    vs_low       = 0;
    last_fs0     = -1;
    last_fs1     = -1;
  endtask

  // One call per CLK: runs at a negedge with k edges seen since release
  task automatic run_cycles(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      int n, h, v;
      reg_out_t e;
      if (tick_pending) begin
        if (sb_q.size() == 0) check("sb.underflow", 32'd1, 32'd0);
        else held = sb_q.pop_front();
        tick_pending = 1'b0;
        pops++;
        if (pops <= int'(FRAME_TICKS)) begin
          if (!hs0) hs_low++;
          if (!vs0) vs_low++;
        end
        if (pops == int'(FRAME_TICKS)) begin
          check("hsync.low_ticks_per_frame", 32'(hs_low), 32'(HS * VT));
          check("vsync.low_ticks_per_frame", 32'(vs_low), 32'(VS * HT));
        end
      end
      check("u0.vga_r", 32'(vr0), 32'(held.r));
      check("u0.vga_g", 32'(vg0), 32'(held.g));
      check("u0.vga_b", 32'(vb0), 32'(held.b));
      check("u0.hsync", 32'(hs0), 32'(held.hs));
      check("u0.vsync", 32'(vs0), 32'(held.vs));
      check_comb("u0", int'(PD), k, tick0, von0, x0, y0, fs0);
      check_comb("u1", 1, k, tick1, von1, x1, y1, fs1);
      if (fs0) begin
        if (last_fs0 >= 0) check("u0.frame_period", 32'(k - last_fs0), 32'(PD * FRAME_TICKS));
        last_fs0 = k;
      end
      if (fs1) begin
        if (last_fs1 >= 0) check("u1.frame_period", 32'(k - last_fs1), 32'(FRAME_TICKS));
        last_fs1 = k;
      end
      if (k % int'(PD) == int'(PD) - 1) begin
        n = k / int'(PD);
        h = n % HT;
        v = (n / HT) % VT;
        r_in = 1'($urandom_range(0, 1));
        g_in = 1'($urandom_range(0, 1));
        b_in = 1'($urandom_range(0, 1));
        e.hs = !(h < int'(HS));
        e.vs = !(v < int'(VS));
        if ((h >= HS + HB) && (h < HS + HB + HV) && (v >= VS + VB) && (v < VS + VB + VV)) begin
          e.r = {8{r_in}};
          e.g = {8{g_in}};
          e.b = {8{b_in}};
        end else begin
          e.r = 8'h00;
          e.g = 8'h00;
          e.b = 8'h00;
        end
        sb_q.push_back(e);
        tick_pending = 1'b1;
      end
      @(negedge CLK);
      k++;
    end
  endtask

  task automatic check_reset_outputs(input string who);
    check({who, ".x_vga"}, 32'(x0), 32'd0);
    check({who, ".y_vga"}, 32'(y0), 32'd0);
    check({who, ".video_on"}, 32'(von0), 32'd0);
    check({who, ".pix_tick"}, 32'(tick0), 32'd0);
    check({who, ".frame_start"}, 32'(fs0), 32'd0);
    check({who, ".hsync"}, 32'(hs0), 32'd1);
    check({who, ".vsync"}, 32'(vs0), 32'd1);
    check({who, ".vga_r"}, 32'(vr0), 32'd0);
    check({who, ".vga_g"}, 32'(vg0), 32'd0);
    check({who, ".vga_b"}, 32'(vb0), 32'd0);
    check({who, ".u1_video_on"}, 32'(von1), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    r_in  = 1'b1;
    g_in  = 1'b0;
    b_in  = 1'b1;
    k     = 0;
    #2;
    check_reset_outputs("por");
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    restart_model();

    // Two full frames, then stop inside the visible window (h=10, v=5)
    run_cycles(int'(2 * PD * FRAME_TICKS) + int'(PD) * (5 * int'(HT) + 10));
    check("pre_reset.video_on", 32'(von0), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    restart_model();

    run_cycles(int'(PD * FRAME_TICKS) + 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-002 SHALL have parameter H_BACK, 48, horizontal back porch in pixels.
REQ-003 SHALL have parameter H_VISIBLE, 640, visible pixels per line.
REQ-004 SHALL have parameter H_FRONT, 16, horizontal front porch in pixels.
REQ-005 SHALL have parameter V_SYNC, 2, vertical sync width in lines.
REQ-006 SHALL have parameter V_BACK, 33, vertical back porch in lines.
REQ-007 SHALL have parameter V_VISIBLE, 480, visible lines per frame.
REQ-008 SHALL have parameter V_FRONT, 10, vertical front porch in lines.
REQ-009 SHALL have parameter PIX_DIV, 2, CLK cycles per pixel (>=1).
REQ-010 SHALL have ports in this order:
- CLK  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- R_IN, G_IN, B_IN  in  1 each  pixel colour from the sprite buffer stage, valid for the current X_VGA/Y_VGA.
- X_VGA  out  10  visible column, already offset by H_SYNC+H_BACK (144).
- Y_VGA  out  10  visible row, already offset by V_SYNC+V_BACK (35).
- VIDEO_ON  out  1  current counter position is visible.
- PIX_TICK  out  1  one-CLK pulse at each pixel advance.
- FRAME_START  out  1  one-CLK pulse at the tick that wraps both counters to 0.
- HSYNC, VSYNC  out  1 each  active-low sync, pipeline-aligned with colour.
- VGA_R, VGA_G, VGA_B  out  8 each  registered, blanked colour.

Function
REQ-011 SHALL hold a divider counter 0..PIX_DIV-1 incrementing every CLK; PIX_TICK=1 while divider==PIX_DIV-1, then divider wraps to 0.
REQ-012 SHALL advance h_count (0..H_TOTAL-1, H_TOTAL=H_SYNC+H_BACK+H_VISIBLE+H_FRONT=800) by one on each PIX_TICK only.
REQ-013 SHALL wrap h_count from H_TOTAL-1 to 0 and, on that same tick, advance v_count (0..V_TOTAL-1, V_TOTAL=525), wrapping v_count from V_TOTAL-1 to 0.
REQ-014 SHALL assert FRAME_START exactly on the tick where h_count==H_TOTAL-1 and v_count==V_TOTAL-1 (simultaneous wrap).
REQ-015 SHALL decode VIDEO_ON = (H_SYNC+H_BACK <= h_count < H_SYNC+H_BACK+H_VISIBLE) AND (V_SYNC+V_BACK <= v_count < V_SYNC+V_BACK+V_VISIBLE), combinationally from the counter registers.
REQ-016 SHALL drive X_VGA = h_count-(H_SYNC+H_BACK) and Y_VGA = v_count-(V_SYNC+V_BACK) while VIDEO_ON, else 0; 10-bit, no negative values ever presented.
REQ-017 SHALL decode raw hsync low while h_count<H_SYNC and raw vsync low while v_count<V_SYNC.
REQ-018 SHALL register colour on PIX_TICK: VGA_R={8{R_IN}} if VIDEO_ON else 8'h00 (same for G, B); outputs hold between ticks.
REQ-019 SHALL register HSYNC/VSYNC from raw sync on the same PIX_TICK, giving one-pixel latency identical to colour.
REQ-020 SHALL treat R_IN/G_IN/B_IN as don't-care when VIDEO_ON=0.
REQ-021 SHALL make all counter widths sufficient for H_TOTAL and V_TOTAL (>=10 bits at defaults); arithmetic is unsigned.

Reset
REQ-022 SHALL on reset=1, asynchronously and without CLK: divider=0, h_count=0, v_count=0, HSYNC=1, VSYNC=1, VGA_R/G/B=8'h00.
REQ-023 SHALL with counters at 0 present PIX_TICK=0 (for PIX_DIV>1), VIDEO_ON=0, X_VGA=0, Y_VGA=0, FRAME_START=0.
REQ-024 SHALL, when reset asserts mid-line or mid-frame, abandon the frame; first PIX_TICK after release occurs PIX_DIV CLK cycles after the first active edge.

Verification
REQ-025 Reset then run, PIX_DIV=2 -> PIX_TICK every 2nd CLK; line period 1600 CLK; FRAME_START period 840000 CLK.
REQ-026 h_count=143->144 and v_count=35 -> VIDEO_ON rises, X_VGA=0, Y_VGA=0; at h_count=783 X_VGA=639; at 784 VIDEO_ON=0, X_VGA=0.
REQ-027 Hold R_IN=1,G_IN=0,B_IN=1 -> during visible VGA_R=8'hFF, VGA_G=8'h00, VGA_B=8'hFF one tick after VIDEO_ON; outside visible all 8'h00.
REQ-028 Check syncs -> HSYNC low exactly 96 ticks per line; VSYNC low exactly 2 lines (1600 ticks) per frame, both delayed one tick vs raw decode.
REQ-029 Assert reset at h_count=500, v_count=300 without a CLK edge -> outputs at reset values immediately; after release counting restarts at 0,0.
REQ-030 PIX_DIV=1 -> PIX_TICK constantly 1, counters advance every CLK, frame period 420000 CLK.
